// File: rtl/trapezoid_render_p.sv
// Trapezoid rasteriser: loads four vertices, emits every lattice point row by row with backpressure.
// Optional `TRAP_PCOUNT_EN adds the done pulse and the accepted-point counter pcount.
module trapezoid_render_p #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          nt,
    input  logic [CW-1:0] xi,
    input  logic [CW-1:0] yi,
    output logic          busy,
    output logic          po,
    output logic [CW-1:0] xo,
    output logic [CW-1:0] yo,
    input  logic          oready
`ifdef TRAP_PCOUNT_EN
    ,
    output logic          done,
    output logic [2*CW:0] pcount
`endif
);

    localparam int AW   = CW + 2;
    localparam int CNTW = (CW + 1 > 4) ? $clog2(CW + 1) : 2;
    localparam logic signed [AW-1:0] ONE_S  = AW'(1);
    localparam logic signed [AW-1:0] ZERO_S = '0;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_ROW, S_EMIT} state_t;

    state_t                 r_state;
    logic [CNTW-1:0]        r_cnt;
    logic                   r_busy, r_po, r_last, r_ydn, r_neg_l, r_neg_r;
    logic [CW-1:0]          r_xo, r_yo, r_y;
    logic [CW-1:0]          r_xul, r_xur, r_xdl, r_xdr, r_yu, r_yd, r_h;
    logic [CW:0]            r_rem_l, r_rem_r;
    logic [CW-1:0]          r_quo_l, r_quo_r;
    logic signed [AW-1:0]   r_al, r_el, r_ar, r_er, r_xr;
`ifdef TRAP_PCOUNT_EN
    logic                   r_done;
    logic [2*CW:0]          r_pcount;
`endif

    logic [2*CW:0]          w_div_l, w_div_r;
    logic [2*AW-1:0]        w_dda_l, w_dda_r;
    logic signed [AW-1:0]   w_ql, w_rl, w_qr, w_rr, w_h, w_xl, w_xr;

    // One restoring-division step; quotient bits shift in as dividend bits shift out.
    function automatic logic [2*CW:0] div_step(input logic [CW:0] rem, input logic [CW-1:0] quo,
                                               input logic [CW-1:0] d);
        logic [CW:0] t;
        t = {rem[CW-1:0], quo[CW-1]};
        if (t >= {1'b0, d})
            return {t - {1'b0, d}, quo[CW-2:0], 1'b1};
        else
            return {t, quo[CW-2:0], 1'b0};
    endfunction

    // Edge position kept as a + e/h with 0 <= e < h; one row step moves it by +/-(q + r/h).
    function automatic logic [2*AW-1:0] dda_step(input logic signed [AW-1:0] a, e, q, r, h,
                                                 input logic neg);
        logic signed [AW-1:0] na, ne;
        if (!neg) begin
            ne = e + r;
            na = a + q;
            if (ne >= h) begin
                ne = ne - h;
                na = na + ONE_S;
            end
        end else begin
            ne = e - r;
            na = a - q;
            if (ne[AW-1]) begin
                ne = ne + h;
                na = na - ONE_S;
            end
        end
        return {na, ne};
    endfunction

    assign w_div_l = div_step(r_rem_l, r_quo_l, r_h);
    assign w_div_r = div_step(r_rem_r, r_quo_r, r_h);
    assign w_ql    = $signed({2'b00, r_quo_l});
    assign w_rl    = $signed({1'b0, r_rem_l});
    assign w_qr    = $signed({2'b00, r_quo_r});
    assign w_rr    = $signed({1'b0, r_rem_r});
    assign w_h     = $signed({2'b00, r_h});
    assign w_dda_l = dda_step(r_al, r_el, w_ql, w_rl, w_h, r_neg_l);
    assign w_dda_r = dda_step(r_ar, r_er, w_qr, w_rr, w_h, r_neg_r);

    // Left bound rounds up, right bound rounds down; a flat trapezoid spans the widest extent.
    always_comb begin
        w_xl = r_al + ((r_el != ZERO_S) ? ONE_S : ZERO_S);
        w_xr = r_ar;
        if (r_h == '0) begin
            w_xl = (r_xdl < r_xul) ? $signed({2'b00, r_xdl}) : $signed({2'b00, r_xul});
            w_xr = (r_xdr > r_xur) ? $signed({2'b00, r_xdr}) : $signed({2'b00, r_xur});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_po    <= 1'b0;
            r_xo    <= '0;
            r_yo    <= '0;
`ifdef TRAP_PCOUNT_EN
            r_done   <= 1'b0;
            r_pcount <= '0;
`endif
        end else begin
`ifdef TRAP_PCOUNT_EN
            r_done <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (nt) begin
                        r_xul   <= xi;
                        r_yu    <= yi;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_LOAD;
`ifdef TRAP_PCOUNT_EN
                        r_pcount <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + CNTW'(1);
                    if (r_cnt == CNTW'(0)) begin
                        r_xur <= xi;
                    end else if (r_cnt == CNTW'(1)) begin
                        r_xdl <= xi;
                        r_yd  <= yi;
                    end else begin
                        r_xdr   <= xi;
                        r_cnt   <= '0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt <= r_cnt + CNTW'(1);
                    if (r_cnt == CNTW'(0)) begin
                        r_h     <= (r_yu >= r_yd) ? r_yu - r_yd : r_yd - r_yu;
                        r_ydn   <= (r_yu < r_yd);
                        r_neg_l <= (r_xul < r_xdl);
                        r_neg_r <= (r_xur < r_xdr);
                        r_quo_l <= (r_xul >= r_xdl) ? r_xul - r_xdl : r_xdl - r_xul;
                        r_quo_r <= (r_xur >= r_xdr) ? r_xur - r_xdr : r_xdr - r_xur;
                        r_rem_l <= '0;
                        r_rem_r <= '0;
                    end else begin
                        {r_rem_l, r_quo_l} <= w_div_l;
                        {r_rem_r, r_quo_r} <= w_div_r;
                        if (r_cnt == CNTW'(CW)) begin
                            r_al    <= $signed({2'b00, r_xdl});
                            r_el    <= ZERO_S;
                            r_ar    <= $signed({2'b00, r_xdr});
                            r_er    <= ZERO_S;
                            r_y     <= r_yd;
                            r_state <= S_ROW;
                        end
                    end
                end
                S_ROW: begin
                    r_last       <= (r_y == r_yu);
                    {r_al, r_el} <= w_dda_l;
                    {r_ar, r_er} <= w_dda_r;
                    r_y          <= r_ydn ? r_y - CW'(1) : r_y + CW'(1);
                    if (w_xl > w_xr) begin
                        if (r_y == r_yu) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
`ifdef TRAP_PCOUNT_EN
                            r_done  <= 1'b1;
`endif
                        end
                    end else begin
                        r_xo    <= w_xl[CW-1:0];
                        r_yo    <= r_y;
                        r_xr    <= w_xr;
                        r_po    <= 1'b1;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (oready) begin
`ifdef TRAP_PCOUNT_EN
                        r_pcount <= r_pcount + {{(2*CW){1'b0}}, 1'b1};
`endif
                        if ($signed({2'b00, r_xo}) == r_xr) begin
                            r_po <= 1'b0;
                            if (r_last) begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
`ifdef TRAP_PCOUNT_EN
                                r_done  <= 1'b1;
`endif
                            end else begin
                                r_state <= S_ROW;
                            end
                        end else begin
                            r_xo <= r_xo + CW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign po   = r_po;
    assign xo   = r_xo;
    assign yo   = r_yo;
`ifdef TRAP_PCOUNT_EN
    assign done   = r_done;
    assign pcount = r_pcount;
`endif

endmodule

// File: doc/trapezoid_render_p.md
Name: trapezoid_render_p

Overview:
- Parametrised successor to the trapezoid rendering engine.
- Takes four vertices of a horizontal-edged trapezoid: upper-left, upper-right, lower-left, lower-right.
- Emits every integer lattice point inside or on the trapezoid, row by row, one point per handshake.
- Adds a coordinate-width parameter, either vertical scan direction, a degenerate single-row case, and output backpressure (oready). It sits between the geometry front-end and the pixel writer.

Parameters:
- CW, 8: coordinate width in bits; all coordinates are unsigned.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- nt  in  1  new trapezoid; marks the cycle that carries vertex 0
- xi  in  CW  input x coordinate
- yi  in  CW  input y coordinate
- busy  out  1  engine occupied; nt is ignored while high
- po  out  1  output point valid
- xo  out  CW  output x
- yo  out  CW  output y
- oready  in  1  downstream accepts the point when po and oready are both high at the clk edge

Behaviour:
- Reset (reset, synchronous, active-high; clock clk): busy, po, xo and yo all go to 0. State returns to IDLE. This holds mid-operation too: all outputs are 0 on the cycle after the reset edge, and the current trapezoid is discarded.
- Load:
  - In IDLE, an edge with nt=1 samples V0=(xul,yu). The next three edges sample V1=(xur,-), V2=(xdl,yd) and V3=(xdr,-), with nt don't-care.
  - yu is taken from V0 and yd from V2; the y values of V1 and V3 are ignored.
  - busy=1 from the cycle after the V0 edge until completion.
- States and transitions:
  - IDLE -> LOAD(3) -> SETUP(CW+1) -> ROW <-> EMIT -> IDLE.
  - SETUP: sequential division. Computes quotient/remainder of |xul-xdl|/H and |xur-xdr|/H, where H=|yu-yd|.
  - ROW: one cycle. Computes the bounds xl and xr for the current row; po=0 in this cycle.
  - EMIT: one point per accepted handshake, x ascending from xl to xr.
- Row order: y steps from yd to yu. The step is +1 if yu>=yd, otherwise -1. Both ends are inclusive.
- Row bounds for the row at y, with t=|y-yd|:
  - xl = ceil(xdl + (xul-xdl)*t/H)
  - xr = floor(xdr + (xur-xdr)*t/H)
  - Results must be exact; implement with an incremental quotient/remainder DDA (no per-row divider). Intermediates need CW+2 signed bits.
- Degenerate case H=0: a single row y=yd with xl=min(xdl,xul) and xr=max(xdr,xur).
- Empty row (xl>xr): ROW emits nothing and advances to the next row, or to done.
- Latency:
  - If V3 is sampled at edge k, the first ROW cycle is k+CW+2 and the first po is at k+CW+3.
  - Each row costs 1 ROW cycle plus one cycle per point while oready=1.
- Backpressure: while po=1 and oready=0, xo, yo and po are held stable. No point is skipped or duplicated.
- Completion: busy=0 on the cycle after the last point is accepted, or after the last ROW if that row is empty. nt is accepted in that same cycle.
- nt while busy=1 is ignored.

Optional Feature:
- Macro: TRAP_PCOUNT_EN.
- With the macro defined, two outputs are added:
  - done, 1 bit: one-cycle pulse on the cycle busy falls.
  - pcount, 2*CW+1 bits: number of points accepted for the current trapezoid. Cleared on the V0 load edge and held after done.
- Without the macro, these ports and their logic are absent and the core behaviour is identical.

Test Plan:
- Rectangle, V=(2,1),(4,1),(2,3),(4,3), oready=1 -> 9 points in order (2,3),(3,3),(4,3),(2,2)..(4,2),(2,1)..(4,1). First po at k+11. busy=0 one cycle after point (4,1).
- Triangle, V=(5,0),(5,0),(1,4),(9,4) -> rows y=4:1..9, y=3:2..8, y=2:3..7, y=1:4..6, y=0:5..5, for 25 points. A gap of exactly one po=0 cycle between rows.
- Backpressure: in the triangle case, hold oready=0 for 5 cycles while (4,3) is presented -> xo/yo remain (4,3) and po=1 throughout. The sequence then resumes with (5,3), for 25 points total.
- Degenerate, V=(3,7),(6,7),(4,7),(5,7) -> single row y=7, points x=3..6 (4 points).
- Empty, V=(5,0),(4,0),(1,2),(0,2) -> zero points. po never rises and busy falls 3 ROW cycles after SETUP. With TRAP_PCOUNT_EN, done pulses and pcount=0.
- Reset mid-EMIT of the triangle -> po=busy=xo=yo=0 the next cycle. A rectangle loaded immediately afterwards renders its 9 points correctly.
